// File: rtl/expr_eval.sv
// Evaluates a streamed ASCII expression of single digits joined by '+' and '*',
// with '*' binding tighter than '+'; '=' latches the final value and rearms.
module expr_eval #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [7:0]   in,
  input  logic         in_valid,
  output logic         ok,
  output logic [W-1:0] value,
  output logic [W-1:0] result,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {
    S_NUM = 2'd0,
    S_OP  = 2'd1,
    S_ERR = 2'd2
  } state_t;

  state_t       state, state_nx;
  logic [W-1:0] acc_sum, acc_sum_nx;
  logic [W-1:0] acc_prod, acc_prod_nx;
  logic [W-1:0] term, term_nx;
  logic         ok_nx, done_nx, err_nx;
  logic [W-1:0] value_nx, result_nx;

  logic         is_digit, is_plus, is_star, is_eq;
  logic [3:0]   digit;
  logic [W-1:0] prod_d;

  // Both helpers wrap silently modulo 2^W.
  function automatic logic [W-1:0] wrap_mul(input logic [W-1:0] a, input logic [3:0] d);
    return W'(a * W'(d));
  endfunction

  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a, input logic [W-1:0] b);
    return W'(a + b);
  endfunction

  // ASCII '0'..'9' are 0x30..0x39, so the low nibble is already the digit value.
  assign is_digit = (in >= 8'h30) && (in <= 8'h39);
  assign is_plus  = (in == 8'h2B);
  assign is_star  = (in == 8'h2A);
  assign is_eq    = (in == 8'h3D);
  assign digit    = in[3:0];
  assign prod_d   = wrap_mul(acc_prod, digit);

  always_comb begin
    state_nx    = state;
    acc_sum_nx  = acc_sum;
    acc_prod_nx = acc_prod;
    term_nx     = term;
    ok_nx       = ok;
    value_nx    = value;
    result_nx   = result;
    err_nx      = err;
    done_nx     = 1'b0;

    if (in_valid) begin
      if (is_eq) begin
        state_nx    = S_NUM;
        acc_sum_nx  = '0;
        acc_prod_nx = W'(1);
        term_nx     = '0;
        ok_nx       = 1'b0;
        value_nx    = '0;
        done_nx     = 1'b1;
        if (state == S_OP) begin
          result_nx = value;
          err_nx    = 1'b0;
        end else begin
          result_nx = '0;
          err_nx    = 1'b1;
        end
      end else begin
        unique case (state)
          S_NUM: begin
            if (is_digit) begin
              term_nx  = prod_d;
              value_nx = wrap_add(acc_sum, prod_d);
              ok_nx    = 1'b1;
              state_nx = S_OP;
            end else begin
              ok_nx    = 1'b0;
              state_nx = S_ERR;
            end
          end
          S_OP: begin
            ok_nx = 1'b0;
            if (is_plus) begin
              acc_sum_nx  = wrap_add(acc_sum, term);
              acc_prod_nx = W'(1);
              state_nx    = S_NUM;
            end else if (is_star) begin
              acc_prod_nx = term;
              state_nx    = S_NUM;
            end else begin
              state_nx = S_ERR;
            end
          end
          S_ERR: begin
            ok_nx = 1'b0;
          end
          default: begin
            ok_nx    = 1'b0;
            state_nx = S_ERR;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= S_NUM;
      acc_sum  <= '0;
      acc_prod <= W'(1);
      term     <= '0;
      ok       <= 1'b0;
      value    <= '0;
      result   <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      acc_sum  <= acc_sum_nx;
      acc_prod <= acc_prod_nx;
      term     <= term_nx;
      ok       <= ok_nx;
      value    <= value_nx;
      result   <= result_nx;
      done     <= done_nx;
      err      <= err_nx;
    end
  end

endmodule

// File: tb/tb_expr_eval.sv
// Self-checking bench for expr_eval: a 16-bit and an 8-bit instance share one stream,
// compared against a string-level evaluator of the current expression.
module tb_expr_eval;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] in;
  logic       in_valid;

  logic        ok_a, done_a, err_a;
  logic [15:0] value_a, result_a;
  logic        ok_b, done_b, err_b;
  logic [7:0]  value_b, result_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] expr_q[$];
  logic       exp_ok, exp_done, exp_err;
  longint     exp_val16, exp_val8, exp_res16, exp_res8;

  always #5 clk = ~clk;

  expr_eval #(.W(16)) dut (
    .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
    .ok(ok_a), .value(value_a), .result(result_a), .done(done_a), .err(err_a)
  );

  expr_eval #(.W(8)) dut8 (
    .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
    .ok(ok_b), .value(value_b), .result(result_b), .done(done_b), .err(err_b)
  );

  function automatic bit is_dig(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic bit is_opc(input logic [7:0] c);
    return (c == 8'h2B) || (c == 8'h2A);
  endfunction

  // Length of the longest prefix of the form digit (op digit)* [op].
  function automatic int valid_len();
    int n = 0;
    for (int i = 0; i < expr_q.size(); i++) begin
      if ((i % 2 == 0) ? is_dig(expr_q[i]) : is_opc(expr_q[i])) n++;
      else break;
    end
    return n;
  endfunction

  // Sum of products of the first n characters (n must end on a digit).
  function automatic longint eval_prefix(input int n, input longint mask);
    longint sum = 0;
    longint prod = 1;
    if (n == 0) return 0;
    for (int i = 0; i < n; i++) begin
      if (is_dig(expr_q[i])) prod = (prod * (longint'(expr_q[i]) - 48)) & mask;
      else if (expr_q[i] == 8'h2B) begin
        sum  = (sum + prod) & mask;
        prod = 1;
      end
    end
    return (sum + prod) & mask;
  endfunction

  task automatic model_consume(input logic [7:0] c);
    int vl, ld;
    bit wf;
    if (c == 8'h3D) begin
      vl = valid_len();
      wf = (vl == expr_q.size()) && (expr_q.size() % 2 == 1);
      exp_err   = !wf;
      exp_res16 = wf ? eval_prefix(expr_q.size(), 64'hFFFF) : 0;
      exp_res8  = wf ? eval_prefix(expr_q.size(), 64'hFF) : 0;
      exp_done  = 1'b1;
      exp_ok    = 1'b0;
      exp_val16 = 0;
      exp_val8  = 0;
      expr_q.delete();
    end else begin
      expr_q.push_back(c);
      vl = valid_len();
      exp_ok    = (vl == expr_q.size()) && is_dig(c);
      ld        = (vl == 0) ? 0 : ((vl % 2 == 1) ? vl : vl - 1);
      exp_val16 = eval_prefix(ld, 64'hFFFF);
      exp_val8  = eval_prefix(ld, 64'hFF);
      exp_done  = 1'b0;
    end
  endtask

  task automatic model_clear();
    expr_q.delete();
    exp_ok = 0; exp_done = 0; exp_err = 0;
    exp_val16 = 0; exp_val8 = 0; exp_res16 = 0; exp_res8 = 0;
  endtask

  // Presents one character for exactly one edge, then idles with junk on in.
  task automatic drive(input logic [7:0] c);
    in       = c;
    in_valid = 1'b1;
    @(posedge clk);
    model_consume(c);
    #1;
    in_valid = 1'b0;
    in       = 8'($urandom);
  endtask

  task automatic test_reset();
    clr = 1'b1; in = 8'h31; in_valid = 1'b1;
    #12;
    checks++;
    if ({ok_a, done_a, err_a, value_a, result_a, ok_b, done_b, err_b, value_b, result_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ok=%0b done=%0b err=%0b value=%0d result=%0d (w8 %0b %0b %0b %0d %0d), want all 0",
               ok_a, done_a, err_a, value_a, result_a, ok_b, done_b, err_b, value_b, result_b);
    end
    in_valid = 1'b0;
    clr = 1'b0;
    model_clear();
    @(posedge clk); #1;
    checks++;
    if ({ok_a, done_a, err_a, value_a, result_a} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got ok=%0b done=%0b err=%0b value=%0d result=%0d, want all 0",
               ok_a, done_a, err_a, value_a, result_a);
    end
  endtask

  task automatic test_expressions();
    string exprs[7] = '{"1+2*3=", "2*3*4+5=", "8=", "1++2=", "4*2=", "9*9*9*9=", "="};
    foreach (exprs[k]) begin
      for (int i = 0; i < exprs[k].len(); i++) begin
        drive(exprs[k][i]);
        checks++;
        if ({ok_a, done_a, err_a} !== {exp_ok, exp_done, exp_err} || value_a !== exp_val16[15:0]) begin
          errors++;
          $display("FAIL expr%0d_char%0d: got ok/done/err=%b%b%b value=%0d, want %b%b%b value=%0d",
                   k, i, ok_a, done_a, err_a, value_a, exp_ok, exp_done, exp_err, exp_val16);
        end
        checks++;
        if (result_a !== exp_res16[15:0] || result_b !== exp_res8[7:0] || value_b !== exp_val8[7:0] || ok_b !== exp_ok) begin
          errors++;
          $display("FAIL expr%0d_char%0d_res: got result=%0d result8=%0d value8=%0d ok8=%0b, want %0d %0d %0d %0b",
                   k, i, result_a, result_b, value_b, ok_b, exp_res16, exp_res8, exp_val8, exp_ok);
        end
      end
      @(posedge clk); #1;
      checks++;
      if (done_a !== 1'b0 || done_b !== 1'b0) begin
        errors++;
        $display("FAIL expr%0d_done_pulse: got done=%0b/%0b one cycle later, want 0", k, done_a, done_b);
      end
      if (k == 0) begin
        checks++;
        if (result_a !== 16'd7 || err_a !== 1'b0) begin
          errors++;
          $display("FAIL result_1p2x3: got %0d err=%0b, want 7 err=0", result_a, err_a);
        end
      end
      if (k == 5) begin
        checks++;
        if (result_b !== 8'd161 || result_a !== 16'd6561) begin
          errors++;
          $display("FAIL result_9x9x9x9: got w8=%0d w16=%0d, want 161 6561", result_b, result_a);
        end
      end
    end
  endtask

  task automatic test_gaps();
    string s = "1+2*3=";
    for (int i = 0; i < s.len(); i++) begin
      drive(s[i]);
      checks++;
      if ({ok_a, done_a, err_a} !== {exp_ok, exp_done, exp_err} || value_a !== exp_val16[15:0] ||
          result_a !== exp_res16[15:0]) begin
        errors++;
        $display("FAIL gap_char%0d: got ok/done/err=%b%b%b value=%0d result=%0d, want %b%b%b %0d %0d",
                 i, ok_a, done_a, err_a, value_a, result_a, exp_ok, exp_done, exp_err, exp_val16, exp_res16);
      end
      for (int g = 0; g < 3; g++) begin
        @(posedge clk); #1;
        checks++;
        if ({ok_a, done_a, err_a} !== {exp_ok, 1'b0, exp_err} || value_a !== exp_val16[15:0] ||
            result_a !== exp_res16[15:0]) begin
          errors++;
          $display("FAIL gap_hold%0d_%0d: got ok/done/err=%b%b%b value=%0d result=%0d, want %b0%b %0d %0d",
                   i, g, ok_a, done_a, err_a, value_a, result_a, exp_ok, exp_err, exp_val16, exp_res16);
        end
      end
    end
    checks++;
    if (result_a !== 16'd7) begin
      errors++;
      $display("FAIL gap_result: got %0d, want 7", result_a);
    end
  endtask

  task automatic test_clr_mid();
    drive("7"); drive("*"); drive("8");
    @(posedge clk);
    #3 clr = 1'b1;
    #1;
    checks++;
    if ({ok_a, done_a, err_a, value_a, result_a, ok_b, done_b, err_b, value_b, result_b} !== '0) begin
      errors++;
      $display("FAIL clr_async: got ok=%0b done=%0b err=%0b value=%0d result=%0d, want all 0",
               ok_a, done_a, err_a, value_a, result_a);
    end
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    @(posedge clk); #1;
    drive("5"); drive("=");
    checks++;
    if (result_a !== 16'd5 || err_a !== 1'b0 || done_a !== 1'b1 || result_b !== 8'd5) begin
      errors++;
      $display("FAIL clr_recover: got result=%0d err=%0b done=%0b result8=%0d, want 5 0 1 5",
               result_a, err_a, done_a, result_b);
    end
  endtask

  task automatic test_random();
    logic [7:0] c;
    int r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      c = 8'h30 + 8'($urandom_range(0, 9));
      else if (r < 65) c = 8'h2B;
      else if (r < 80) c = 8'h2A;
      else if (r < 92) c = 8'h3D;
      else             c = 8'h41 + 8'($urandom_range(0, 20));
      drive(c);
      checks++;
      if ({ok_a, done_a, err_a} !== {exp_ok, exp_done, exp_err} || value_a !== exp_val16[15:0] ||
          result_a !== exp_res16[15:0]) begin
        errors++;
        $display("FAIL rand%0d_w16 char=%02h: got ok/done/err=%b%b%b value=%0d result=%0d, want %b%b%b %0d %0d",
                 n, c, ok_a, done_a, err_a, value_a, result_a, exp_ok, exp_done, exp_err, exp_val16, exp_res16);
      end
      checks++;
      if ({ok_b, done_b, err_b} !== {exp_ok, exp_done, exp_err} || value_b !== exp_val8[7:0] ||
          result_b !== exp_res8[7:0]) begin
        errors++;
        $display("FAIL rand%0d_w8 char=%02h: got ok/done/err=%b%b%b value=%0d result=%0d, want %b%b%b %0d %0d",
                 n, c, ok_b, done_b, err_b, value_b, result_b, exp_ok, exp_done, exp_err, exp_val8, exp_res8);
      end
      r = $urandom_range(0, 2);
      for (int g = 0; g < r; g++) begin
        @(posedge clk); #1;
        checks++;
        if (done_a !== 1'b0 || ok_a !== exp_ok || value_a !== exp_val16[15:0]) begin
          errors++;
          $display("FAIL rand%0d_idle: got done=%0b ok=%0b value=%0d, want 0 %0b %0d",
                   n, done_a, ok_a, value_a, exp_ok, exp_val16);
        end
      end
    end
  endtask

  initial begin
    clr = 1'b1; in = '0; in_valid = 1'b0;
    model_clear();
    test_reset();
    test_expressions();
    test_gaps();
    test_clr_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
